// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state encoding, opcode/ALU codes and per-state control decode.
//  Contents: statetype (4-bit FSM state), ctrl_t (registered Moore control word),
//  opcode/funct/ALUOp/ALUControl constants, state_ctrl() mapping a state to its Moore outputs.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } statetype;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] AC_AND = 3'b000;
    localparam logic [2:0] AC_OR  = 3'b001;
    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_BAD = 3'b011;
    localparam logic [2:0] AC_SUB = 3'b110;
    localparam logic [2:0] AC_SLT = 3'b111;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input statetype s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:              begin c.pcwrite = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:             c.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:              c.iord = 1'b1;
            S_MEMWB:              begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:              begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE:            begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:              begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            S_BRANCH:             begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            S_ADDIWB:             c.regwrite = 1'b1;
            S_JUMP:               begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
            default:              c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath signal bundle.
//  master (controller): takes op/funct/zero, drives enables, mux selects, alucontrol, state, halted.
//  slave  (datapath/bench): the mirror view.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       halted;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, halted
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, halted
    );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// aludec: combinational ALUOp + funct -> 3-bit ALUControl.
//  i_aluop  2  00 add, 01 sub, 10 by funct, 11 add
//  i_funct  6  instr[5:0]
//  o_alucontrol 3  alu operation code (011 for unknown funct)
module aludec
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);
    logic [2:0] w_fn;

    always_comb begin
        case (i_funct)
            FN_ADD:  w_fn = AC_ADD;
            FN_SUB:  w_fn = AC_SUB;
            FN_AND:  w_fn = AC_AND;
            FN_OR:   w_fn = AC_OR;
            FN_SLT:  w_fn = AC_SLT;
            default: w_fn = AC_BAD;
        endcase
    end

    assign o_alucontrol = (i_aluop == ALUOP_SUB)   ? AC_SUB :
                          (i_aluop == ALUOP_FUNCT) ? w_fn   : AC_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/writeback of the multicycle core.
//  clk    in  rising-edge clock
//  reset  in  synchronous active-high; write enables are forced low while it is high
//  bus    master modport: op/funct/zero in; pcen, irwrite, memwrite, regwrite, iord, memtoreg,
//         regdst, alusrca, alusrcb, pcsrc, alucontrol, state, halted out
//  ILLEGAL_HALT  0: unknown opcode returns to FETCH, 1: parks in HALT until reset
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);
    statetype   r_state;
    ctrl_t      r_ctrl;
    statetype   w_next;
    statetype   w_load;
    logic [2:0] w_alucontrol;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            S_MEMADR:   w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    assign w_load = reset ? S_FETCH : w_next;

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        r_state <= w_load;
        r_ctrl  <= state_ctrl(w_load);
    end

    aludec u_aludec (
        .i_aluop      (r_ctrl.aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (w_alucontrol)
    );

    // Enables are masked during the reset cycle so an abandoned instruction never writes.
    assign bus.pcen       = ~reset & (r_ctrl.pcwrite | (r_ctrl.branch & bus.zero));
    assign bus.irwrite    = ~reset & r_ctrl.irwrite;
    assign bus.memwrite   = ~reset & r_ctrl.memwrite;
    assign bus.regwrite   = ~reset & r_ctrl.regwrite;
    assign bus.iord       = r_ctrl.iord;
    assign bus.memtoreg   = r_ctrl.memtoreg;
    assign bus.regdst     = r_ctrl.regdst;
    assign bus.alusrca    = r_ctrl.alusrca;
    assign bus.alusrcb    = r_ctrl.alusrcb;
    assign bus.pcsrc      = r_ctrl.pcsrc;
    assign bus.alucontrol = w_alucontrol;
    assign bus.state      = r_state;
    assign bus.halted     = (r_state == S_HALT);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed + random instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_controller_if bus ();
    multicycle_controller_if bus_h ();

    assign bus_h.op    = bus.op;
    assign bus_h.funct = bus.funct;
    assign bus_h.zero  = bus.zero;

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h.master));

    always #5 clk = ~clk;

    logic [19:0] o_v, o_h;
    assign o_v = {bus.state, bus.halted, bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord,
                  bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
    assign o_h = {bus_h.state, bus_h.halted, bus_h.pcen, bus_h.irwrite, bus_h.memwrite, bus_h.regwrite, bus_h.iord,
                  bus_h.memtoreg, bus_h.regdst, bus_h.alusrca, bus_h.alusrcb, bus_h.pcsrc, bus_h.alucontrol};

    function automatic logic [2:0] funct_ctl(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b011;
        endcase
    endfunction

    function automatic int ilen(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction (k=0 is its fetch); k>=2 of an unknown op models HALT.
    function automatic logic [19:0] model(input logic [5:0] op, input logic [5:0] f, input logic z, input int k, input bit rst);
        logic [3:0] st;
        logic h, pe, ir, mw, rw, io, mr, rd, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {st, h, pe, ir, mw, rw, io, mr, rd, sa, sb, ps} = '0;
        ac = 3'b010;
        if (k == 0) begin st = 4'd0; pe = 1'b1; ir = 1'b1; sb = 2'b01; end
        else if (k == 1) begin st = 4'd1; sb = 2'b11; end
        else begin
            case (op)
                6'b100011: if (k == 2) begin st = 4'd2; sa = 1'b1; sb = 2'b10; end
                           else if (k == 3) begin st = 4'd3; io = 1'b1; end
                           else begin st = 4'd4; rw = 1'b1; mr = 1'b1; end
                6'b101011: if (k == 2) begin st = 4'd2; sa = 1'b1; sb = 2'b10; end
                           else begin st = 4'd5; io = 1'b1; mw = 1'b1; end
                6'b000000: if (k == 2) begin st = 4'd6; sa = 1'b1; ac = funct_ctl(f); end
                           else begin st = 4'd7; rw = 1'b1; rd = 1'b1; end
                6'b001000: if (k == 2) begin st = 4'd9; sa = 1'b1; sb = 2'b10; end
                           else begin st = 4'd10; rw = 1'b1; end
                6'b000100: begin st = 4'd8; sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
                6'b000010: begin st = 4'd11; pe = 1'b1; ps = 2'b10; end
                default:   begin st = 4'd12; h = 1'b1; end
            endcase
        end
        if (rst) {pe, ir, mw, rw} = 4'b0000;
        return {st, h, pe, ir, mw, rw, io, mr, rd, sa, sb, ps, ac};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; zmode 0/1 fixes zero, 2 randomizes it every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode, input bit chk_h);
        bus.op = op;
        bus.funct = f;
        for (int k = 0; k < ilen(op); k++) begin
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            chk($sformatf("op%b_f%b_k%0d", op, f, k), o_v, model(op, f, bus.zero, k, 1'b0));
            if (chk_h) chk($sformatf("h_op%b_k%0d", op, k), o_h, model(op, f, bus.zero, k, 1'b0));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.op = 6'b0;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", o_v, model(6'b0, 6'b0, 1'b0, 0, 1'b1));
        chk("reset_h", o_h, model(6'b0, 6'b0, 1'b0, 0, 1'b1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, 2, 1'b1);
        run_instr(6'b000000, 6'b100010, 2, 1'b1);
        run_instr(6'b000100, 6'b000000, 1, 1'b1);
        run_instr(6'b000100, 6'b000000, 0, 1'b1);
        run_instr(6'b101011, 6'b000000, 2, 1'b1);
        run_instr(6'b000010, 6'b000000, 2, 1'b1);
        run_instr(6'b000000, 6'b100111, 2, 1'b1);
        run_instr(6'b001000, 6'b000000, 2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(ops[$urandom_range(0, 5)], f, 2, 1'b1);
        end
        bus.op = 6'b101011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("sw_pre_reset_k%0d", k), o_v, model(6'b101011, 6'b0, bus.zero, k, 1'b0));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_memwr", o_v, model(6'b101011, 6'b0, 1'b0, 3, 1'b1));
        chk("reset_in_memwr_h", o_h, model(6'b101011, 6'b0, 1'b0, 3, 1'b1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, 2, 1'b1);
        run_instr(6'b111111, 6'b000000, 2, 1'b0);
        bus.op = 6'b000010;
        for (int k = 0; k < 3; k++) begin
            bus.zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("after_illegal_k%0d", k), o_v, model(6'b000010, 6'b0, bus.zero, k, 1'b0));
            chk($sformatf("halt_hold_k%0d", k), o_h, model(6'b111111, 6'b0, 1'b0, 2, 1'b0));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("halt_during_reset", o_h, model(6'b111111, 6'b0, 1'b0, 2, 1'b1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b001000, 6'b000000, 2, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
